// File: rtl/dec_issue_ctrl_pkg.sv
// rtl/dec_issue_ctrl_pkg.sv - shared types and defaults for the dec0->dec1 issue controller
package dec_issue_ctrl_pkg;

    localparam int NB_REGS_DEFAULT  = 32;
    localparam int LONG_LAT_DEFAULT = 34;

    typedef enum logic {
        ISS_IDLE,
        ISS_LONG_BUSY
    } issue_state_t;

    // x0 is hard-wired, so a zero address never participates in a dependency
    function automatic logic adr_match(input logic v, input logic [4:0] a, input logic [4:0] b);
        return v & (a != 5'd0) & (a == b);
    endfunction

endpackage

// File: rtl/dec_issue_ctrl_if.sv
// rtl/dec_issue_ctrl_if.sv - dec0 request, writeback, flush and issue status bundle
interface dec_issue_ctrl_if #(
    parameter int NB_REGS = 32
);
    logic               dec0_v_i;
    logic               rs1_v_i;
    logic [4:0]         rs1_adr_i;
    logic               rs2_v_i;
    logic [4:0]         rs2_adr_i;
    logic               rd_v_i;
    logic [4:0]         rd_adr_i;
    logic               is_load_i;
    logic               is_long_i;
    logic               mem_wbk_v_i;
    logic [4:0]         mem_wbk_adr_i;
    logic               branch_v_q_i;
    logic               issue_v_o;
    logic               stall_o;
    logic               long_busy_o;
    logic               long_done_o;
    logic [NB_REGS-1:0] pending_o;

    modport master (
        output dec0_v_i, rs1_v_i, rs1_adr_i, rs2_v_i, rs2_adr_i, rd_v_i, rd_adr_i,
               is_load_i, is_long_i, mem_wbk_v_i, mem_wbk_adr_i, branch_v_q_i,
        input  issue_v_o, stall_o, long_busy_o, long_done_o, pending_o
    );

    modport slave (
        input  dec0_v_i, rs1_v_i, rs1_adr_i, rs2_v_i, rs2_adr_i, rd_v_i, rd_adr_i,
               is_load_i, is_long_i, mem_wbk_v_i, mem_wbk_adr_i, branch_v_q_i,
        output issue_v_o, stall_o, long_busy_o, long_done_o, pending_o
    );
endinterface

// File: rtl/dec_issue_ctrl_scoreboard.sv
// rtl/dec_issue_ctrl_scoreboard.sv - pending-load register scoreboard with flush undo
module reg_scoreboard #(
    parameter int NB_REGS = 32
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               set_v,
    input  logic [4:0]         set_adr,
    input  logic               clr_v,
    input  logic [4:0]         clr_adr,
    input  logic               undo_v,
    input  logic [4:0]         rd1_adr,
    input  logic [4:0]         rd2_adr,
    input  logic [4:0]         waw_adr,
    output logic               rd1_pend,
    output logic               rd2_pend,
    output logic               waw_pend,
    output logic [NB_REGS-1:0] pending
);
    logic [NB_REGS-1:0] pending_q;
    logic [NB_REGS-1:0] pending_d;
    logic [NB_REGS-1:0] last_set_q;
    logic [NB_REGS-1:0] set_mask;
    logic [NB_REGS-1:0] clr_mask;
    logic [NB_REGS-1:0] undo_mask;

    // set is applied last so a load issuing alongside a writeback of the same register stays pending
    always_comb begin
        set_mask  = set_v  ? (NB_REGS'(1) << set_adr) : '0;
        clr_mask  = clr_v  ? (NB_REGS'(1) << clr_adr) : '0;
        undo_mask = undo_v ? last_set_q : '0;
        pending_d = ((pending_q & ~clr_mask & ~undo_mask) | set_mask) & ~NB_REGS'(1);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pending_q  <= '0;
            last_set_q <= '0;
        end else begin
            pending_q  <= pending_d;
            last_set_q <= set_mask;
        end
    end

    assign rd1_pend = pending_q[rd1_adr];
    assign rd2_pend = pending_q[rd2_adr];
    assign waw_pend = pending_q[waw_adr];
    assign pending  = pending_q;
endmodule

// File: rtl/dec_issue_ctrl.sv
// rtl/dec_issue_ctrl.sv - dec0->dec1 issue/hazard control with load scoreboard and long-unit sequencing
module dec_issue_ctrl
    import dec_issue_ctrl_pkg::*;
#(
    parameter int NB_REGS  = NB_REGS_DEFAULT,
    parameter int LONG_LAT = LONG_LAT_DEFAULT,
    parameter int CNT_W    = $clog2(LONG_LAT + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    dec_issue_ctrl_if.slave  bus
);
    issue_state_t       state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [4:0]         long_rd_q, long_rd_d;
    logic               long_new_q, long_new_d;
    logic               long_done_q, long_done_d;
    logic               rd1_pend, rd2_pend, waw_pend;
    logic [NB_REGS-1:0] pending;
    logic               busy, hz_sb, hz_long, hz, issue_v;

    reg_scoreboard #(.NB_REGS(NB_REGS)) u_sb (
        .clk      (clk),
        .reset_n  (reset_n),
        .set_v    (issue_v & bus.is_load_i & bus.rd_v_i & (bus.rd_adr_i != 5'd0)),
        .set_adr  (bus.rd_adr_i),
        .clr_v    (bus.mem_wbk_v_i),
        .clr_adr  (bus.mem_wbk_adr_i),
        .undo_v   (bus.branch_v_q_i),
        .rd1_adr  (bus.rs1_adr_i),
        .rd2_adr  (bus.rs2_adr_i),
        .waw_adr  (bus.rd_adr_i),
        .rd1_pend (rd1_pend),
        .rd2_pend (rd2_pend),
        .waw_pend (waw_pend),
        .pending  (pending)
    );

    assign busy  = (state_q == ISS_LONG_BUSY);
    assign hz_sb = (bus.rs1_v_i & rd1_pend) | (bus.rs2_v_i & rd2_pend) | (bus.rd_v_i & waw_pend);
    // the long result has no fast-forward path until the done pulse, so its rd is a hazard too
    assign hz_long = busy & (bus.is_long_i
                           | adr_match(bus.rs1_v_i, bus.rs1_adr_i, long_rd_q)
                           | adr_match(bus.rs2_v_i, bus.rs2_adr_i, long_rd_q)
                           | adr_match(bus.rd_v_i,  bus.rd_adr_i,  long_rd_q));
    assign hz      = hz_sb | hz_long;
    assign issue_v = reset_n & bus.dec0_v_i & ~hz & ~bus.branch_v_q_i;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        long_rd_d   = long_rd_q;
        long_new_d  = 1'b0;
        long_done_d = 1'b0;
        case (state_q)
            ISS_IDLE: begin
                if (issue_v && bus.is_long_i) begin
                    state_d    = ISS_LONG_BUSY;
                    cnt_d      = CNT_W'(LONG_LAT - 1);
                    long_rd_d  = bus.rd_v_i ? bus.rd_adr_i : 5'd0;
                    long_new_d = 1'b1;
                end
            end
            ISS_LONG_BUSY: begin
                // only the op squashed in dec1 is aborted; older ones run to completion
                if (bus.branch_v_q_i && long_new_q) begin
                    state_d = ISS_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = (cnt_q != '0) ? cnt_q - CNT_W'(1) : '0;
                    if (cnt_q == CNT_W'(1)) begin
                        long_done_d = 1'b1;
                        state_d     = ISS_IDLE;
                    end
                end
            end
            default: state_d = ISS_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= ISS_IDLE;
            cnt_q       <= '0;
            long_rd_q   <= 5'd0;
            long_new_q  <= 1'b0;
            long_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            long_rd_q   <= long_rd_d;
            long_new_q  <= long_new_d;
            long_done_q <= long_done_d;
        end
    end

    assign bus.issue_v_o   = issue_v;
    assign bus.stall_o     = reset_n & bus.dec0_v_i & hz & ~bus.branch_v_q_i;
    assign bus.long_busy_o = reset_n & busy;
    assign bus.long_done_o = reset_n & long_done_q;
    assign bus.pending_o   = reset_n ? pending : '0;
endmodule
